// File: rtl/gf180mcu_fd_sc_mcu9t5v0__oainm_pkg.sv
// Shared definitions for the pipelined OR-AND-invert / AND-OR-invert macro:
// mode encoding, legal pipeline depths and the operand bit-position helper.
package gf180mcu_fd_sc_mcu9t5v0__oainm_pkg;

    // Per-transaction function select, carried alongside the operands.
    localparam logic MODE_OAI = 1'b0;
    localparam logic MODE_AOI = 1'b1;

    // Supported pipeline depths.
    localparam int STAGES_MIN = 1;
    localparam int STAGES_MAX = 2;

    // Flat position of operand bit (group g, member m, lane w) inside IN.
    function automatic int bit_index(input int g, input int m, input int w,
                                     input int group_size, input int width);
        return (g * group_size + m) * width + w;
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__oainm_slice.sv
// One valid/ready register slice holding a single entry. Ready is
// combinational (empty or draining this edge); there is no skid buffer.
module gf180mcu_fd_sc_mcu9t5v0__oainm_slice #(
    parameter int         W          = 1,
    parameter logic [W-1:0] RESET_DATA = '0
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         up_valid,
    output logic         up_ready,
    input  logic [W-1:0] up_data,
    output logic         dn_valid,
    input  logic         dn_ready,
    output logic [W-1:0] dn_data
);

    // The slice can take a new entry when it is empty or its entry retires now.
    assign up_ready = !dn_valid || dn_ready;

    // Valid follows the handshake every edge; the payload only loads on accept.
    always_ff @(posedge CLK) begin
        if (RST) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            dn_valid <= 1'b0;
            // NOTE: the payload is reset too, because its reset value is
            // architecturally visible (ZN must read all ones out of reset).
            dn_data  <= RESET_DATA;
        end else begin
            if (up_ready) begin
                dn_valid <= up_valid;
            end
            if (up_valid && up_ready) begin
                dn_data <= up_data;
            end
        end
    end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__oainm_pipe.sv
// Pipelined GROUPS x GROUP_SIZE OR-AND-invert / AND-OR-invert over WIDTH
// independent lanes, behind 1 or 2 valid/ready register stages.
module gf180mcu_fd_sc_mcu9t5v0__oainm_pipe
    import gf180mcu_fd_sc_mcu9t5v0__oainm_pkg::*;
#(
    parameter int GROUPS     = 3,
    parameter int GROUP_SIZE = 2,
    parameter int WIDTH      = 1,
    parameter int STAGES     = 1
) (
    input  logic                                CLK,
    input  logic                                RST,
    input  logic                                IN_VALID,
    output logic                                IN_READY,
    input  logic                                MODE,
    input  logic [GROUPS*GROUP_SIZE*WIDTH-1:0]  IN,
    output logic                                OUT_VALID,
    input  logic                                OUT_READY,
    output logic [WIDTH-1:0]                    ZN
);

    localparam int N_IN    = GROUPS * GROUP_SIZE * WIDTH;
    localparam int N_TERMS = GROUPS * WIDTH;

    // Group terms: OR of members for OAI, AND of members for AOI.
    // Term for group g, lane w lives at bit g*WIDTH + w.
    function automatic logic [N_TERMS-1:0] group_terms(input logic [N_IN-1:0] din,
                                                       input logic mode);
        logic [N_TERMS-1:0] terms;
        logic               acc;
        logic               b;
        terms = '0;
        for (int g = 0; g < GROUPS; g++) begin
            for (int w = 0; w < WIDTH; w++) begin
                acc = (mode == MODE_AOI);
                for (int m = 0; m < GROUP_SIZE; m++) begin
                    b   = din[bit_index(g, m, w, GROUP_SIZE, WIDTH)];
                    acc = (mode == MODE_AOI) ? (acc & b) : (acc | b);
                end
                terms[g*WIDTH+w] = acc;
            end
        end
        return terms;
    endfunction

    // Final reduce-and-invert across groups: NAND for OAI, NOR for AOI.
    function automatic logic [WIDTH-1:0] final_reduce(input logic [N_TERMS-1:0] terms,
                                                      input logic mode);
        logic [WIDTH-1:0] zn;
        logic             acc;
        zn = '1;
        for (int w = 0; w < WIDTH; w++) begin
            acc = (mode != MODE_AOI);
            for (int g = 0; g < GROUPS; g++) begin
                acc = (mode == MODE_AOI) ? (acc | terms[g*WIDTH+w])
                                         : (acc & terms[g*WIDTH+w]);
            end
            zn[w] = ~acc;
        end
        return zn;
    endfunction

    if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
        $error("oainm_pipe: STAGES must be 1 or 2");
    end else if (STAGES == 1) begin : g_one_stage
        logic [WIDTH-1:0] zn_next;

        // Whole function evaluated ahead of the single result register.
        always_comb begin
            zn_next = final_reduce(group_terms(IN, MODE), MODE);
        end

        gf180mcu_fd_sc_mcu9t5v0__oainm_slice #(
            .W          (WIDTH),
            .RESET_DATA ({WIDTH{1'b1}})
        ) u_out (
            .CLK      (CLK),
            .RST      (RST),
            .up_valid (IN_VALID),
            .up_ready (IN_READY),
            .up_data  (zn_next),
            .dn_valid (OUT_VALID),
            .dn_ready (OUT_READY),
            .dn_data  (ZN)
        );
    end else begin : g_two_stage
        logic               s1_valid;
        logic               s1_ready;
        logic [N_TERMS:0]   s1_next;
        logic [N_TERMS:0]   s1_data;
        logic [WIDTH-1:0]   zn_next;

        // Stage 1 payload: mode on top of the group terms.
        always_comb begin
            s1_next = {MODE, group_terms(IN, MODE)};
        end

        gf180mcu_fd_sc_mcu9t5v0__oainm_slice #(
            .W          (N_TERMS + 1),
            .RESET_DATA ('0)
        ) u_terms (
            .CLK      (CLK),
            .RST      (RST),
            .up_valid (IN_VALID),
            .up_ready (IN_READY),
            .up_data  (s1_next),
            .dn_valid (s1_valid),
            .dn_ready (s1_ready),
            .dn_data  (s1_data)
        );

        // Stage 2 input: reduce the registered terms with their own mode.
        always_comb begin
            zn_next = final_reduce(s1_data[N_TERMS-1:0], s1_data[N_TERMS]);
        end

        gf180mcu_fd_sc_mcu9t5v0__oainm_slice #(
            .W          (WIDTH),
            .RESET_DATA ({WIDTH{1'b1}})
        ) u_out (
            .CLK      (CLK),
            .RST      (RST),
            .up_valid (s1_valid),
            .up_ready (s1_ready),
            .up_data  (zn_next),
            .dn_valid (OUT_VALID),
            .dn_ready (OUT_READY),
            .dn_data  (ZN)
        );
    end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__oainm_pipe.sv
// Directed bench: default OAI222 configuration (A) and a 2x3x4, two-stage
// configuration (B) sharing clock and reset.
module tb_gf180mcu_fd_sc_mcu9t5v0__oainm_pipe;
    import gf180mcu_fd_sc_mcu9t5v0__oainm_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Configuration A: GROUPS=3, GROUP_SIZE=2, WIDTH=1, STAGES=1
    logic       a_in_valid, a_in_ready, a_mode, a_out_valid, a_out_ready;
    logic [5:0] a_in;
    logic [0:0] a_zn;

    // Configuration B: GROUPS=2, GROUP_SIZE=3, WIDTH=4, STAGES=2
    logic        b_in_valid, b_in_ready, b_mode, b_out_valid, b_out_ready;
    logic [23:0] b_in;
    logic [3:0]  b_zn;

    logic [3:0] b_q[$];
    int         b_acc = 0;

    gf180mcu_fd_sc_mcu9t5v0__oainm_pipe #(
        .GROUPS(3), .GROUP_SIZE(2), .WIDTH(1), .STAGES(1)
    ) u_a (
        .CLK(clk), .RST(rst), .IN_VALID(a_in_valid), .IN_READY(a_in_ready),
        .MODE(a_mode), .IN(a_in), .OUT_VALID(a_out_valid),
        .OUT_READY(a_out_ready), .ZN(a_zn)
    );

    gf180mcu_fd_sc_mcu9t5v0__oainm_pipe #(
        .GROUPS(2), .GROUP_SIZE(3), .WIDTH(4), .STAGES(2)
    ) u_b (
        .CLK(clk), .RST(rst), .IN_VALID(b_in_valid), .IN_READY(b_in_ready),
        .MODE(b_mode), .IN(b_in), .OUT_VALID(b_out_valid),
        .OUT_READY(b_out_ready), .ZN(b_zn)
    );

    // OAI222 written out directly: groups are IN[1:0], IN[3:2], IN[5:4].
    function automatic logic model_oai222(input logic [5:0] d);
        return ~((d[0] | d[1]) & (d[2] | d[3]) & (d[4] | d[5]));
    endfunction

    // Reference for configuration B, phrased as "some group empty" /
    // "some group complete" per lane.
    function automatic logic [3:0] model_b(input logic [23:0] d, input logic mode);
        logic [3:0] zn;
        int         ones;
        logic       any_empty;
        logic       any_full;
        for (int w = 0; w < 4; w++) begin
            any_empty = 1'b0;
            any_full  = 1'b0;
            for (int g = 0; g < 2; g++) begin
                ones = 0;
                for (int m = 0; m < 3; m++) ones += int'(d[bit_index(g, m, w, 3, 4)]);
                if (ones == 0) any_empty = 1'b1;
                if (ones == 3) any_full  = 1'b1;
            end
            zn[w] = (mode == MODE_OAI) ? any_empty : ~any_full;
        end
        return zn;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle on B: drive, retire against the scoreboard, record accepts.
    task automatic b_cycle(input logic v, input logic [23:0] d, input logic m,
                           input logic rdy);
        logic [3:0] exp;
        b_in_valid  = v;
        b_in        = d;
        b_mode      = m;
        b_out_ready = rdy;
        #1;
        if (b_out_valid && b_out_ready) begin
            checks++;
            if (b_q.size() == 0) begin
                errors++;
                $display("FAIL b_spurious_output zn=%h with nothing outstanding", b_zn);
            end else begin
                exp = b_q.pop_front();
                if (b_zn !== exp) begin
                    errors++;
                    $display("FAIL b_retire_zn got=%b want=%b", b_zn, exp);
                end
            end
        end
        if (b_in_valid && b_in_ready) begin
            b_q.push_back(model_b(d, m));
            b_acc++;
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_in_valid = 1'b0; a_in = '0; a_mode = MODE_OAI; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in = '0; b_mode = MODE_OAI; b_out_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_a_out_valid got=%b want=0", a_out_valid); end
        checks++;
        if (a_zn !== 1'b1) begin errors++; $display("FAIL reset_a_zn got=%b want=1", a_zn); end
        checks++;
        if (b_out_valid !== 1'b0) begin errors++; $display("FAIL reset_b_out_valid got=%b want=0", b_out_valid); end
        checks++;
        if (b_zn !== 4'hF) begin errors++; $display("FAIL reset_b_zn got=%b want=1111", b_zn); end
        rst = 1'b0;
        #1;
        checks++;
        if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_a_in_ready got=%b want=1", a_in_ready); end
        checks++;
        if (b_in_ready !== 1'b1) begin errors++; $display("FAIL reset_b_in_ready got=%b want=1", b_in_ready); end
    endtask

    // All 64 patterns streamed back to back; each result one cycle later.
    task automatic test_oai222_all();
        logic [5:0] d;
        for (int i = 0; i < 64; i++) begin
            d = 6'(i);
            a_in = d; a_mode = MODE_OAI; a_in_valid = 1'b1; a_out_ready = 1'b1;
            tick();
            checks++;
            if (a_out_valid !== 1'b1 || a_zn !== model_oai222(d)) begin
                errors++;
                $display("FAIL oai222_pattern_%0d got valid=%b zn=%b want valid=1 zn=%b",
                         i, a_out_valid, a_zn, model_oai222(d));
            end
            if (i == 21) begin
                checks++;
                if (a_zn !== 1'b0) begin errors++; $display("FAIL oai222_010101 got=%b want=0", a_zn); end
            end
            if (i == 3) begin
                checks++;
                if (a_zn !== 1'b1) begin errors++; $display("FAIL oai222_000011 got=%b want=1", a_zn); end
            end
        end
        a_in_valid = 1'b0;
        tick();
        checks++;
        if (a_out_valid !== 1'b0) begin errors++; $display("FAIL oai222_idle_valid got=%b want=0", a_out_valid); end
    endtask

    // Hand-built lane vectors on B with two-cycle latency.
    task automatic test_lanes();
        logic [23:0] vin  [3] = '{24'h000111, 24'h444088, 24'h200003};
        logic        vmode[3] = '{MODE_AOI,   MODE_AOI,   MODE_OAI};
        logic [3:0]  vexp [3] = '{4'b1110,    4'b1011,    4'b1101};
        for (int i = 0; i < 3; i++) begin
            b_in = vin[i]; b_mode = vmode[i]; b_in_valid = 1'b1; b_out_ready = 1'b1;
            tick();
            b_in_valid = 1'b0;
            checks++;
            if (b_out_valid !== 1'b0) begin errors++; $display("FAIL lanes_%0d_early_valid got=%b want=0", i, b_out_valid); end
            tick();
            checks++;
            if (b_out_valid !== 1'b1 || b_zn !== vexp[i]) begin
                errors++;
                $display("FAIL lanes_%0d got valid=%b zn=%b want valid=1 zn=%b", i, b_out_valid, b_zn, vexp[i]);
            end
        end
        tick();
        checks++;
        if (b_out_valid !== 1'b0) begin errors++; $display("FAIL lanes_drain_valid got=%b want=0", b_out_valid); end
    endtask

    // Five stalled cycles: two accepts, then IN_READY low and ZN held.
    task automatic test_stall();
        logic [3:0] held;
        int         acc0;
        acc0 = b_acc;
        held = '0;
        for (int c = 0; c < 5; c++) begin
            b_cycle(1'b1, 24'($urandom), 1'(c), 1'b0);
            if (c == 1) held = b_zn;
            if (c >= 2) begin
                checks++;
                if (b_out_valid !== 1'b1 || b_zn !== held) begin
                    errors++;
                    $display("FAIL stall_hold_%0d got valid=%b zn=%b want valid=1 zn=%b", c, b_out_valid, b_zn, held);
                end
            end
        end
        checks++;
        if (b_acc - acc0 != 2) begin errors++; $display("FAIL stall_accept_count got=%0d want=2", b_acc - acc0); end
        checks++;
        if (b_in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got=%b want=0", b_in_ready); end
        for (int c = 0; c < 6; c++) b_cycle(1'b0, '0, MODE_OAI, 1'b1);
        checks++;
        if (b_q.size() != 0 || b_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_drain outstanding=%0d valid=%b want 0 and 0", b_q.size(), b_out_valid);
        end
    endtask

    // Full-throughput back-to-back transactions alternating mode.
    task automatic test_back_to_back();
        int acc0;
        acc0 = b_acc;
        for (int i = 0; i < 20; i++) b_cycle(1'b1, 24'($urandom), 1'(i), 1'b1);
        checks++;
        if (b_acc - acc0 != 20) begin errors++; $display("FAIL b2b_accepts got=%0d want=20", b_acc - acc0); end
        for (int i = 0; i < 4; i++) b_cycle(1'b0, '0, MODE_OAI, 1'b1);
        checks++;
        if (b_q.size() != 0) begin errors++; $display("FAIL b2b_drain outstanding=%0d want=0", b_q.size()); end
    endtask

    // Reset while both stages of B are full.
    task automatic test_reset_full();
        for (int c = 0; c < 3; c++) b_cycle(1'b1, 24'($urandom), MODE_AOI, 1'b0);
        b_in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        b_q.delete();
        #1;
        checks++;
        if (b_out_valid !== 1'b0) begin errors++; $display("FAIL rstfull_out_valid got=%b want=0", b_out_valid); end
        checks++;
        if (b_zn !== 4'hF) begin errors++; $display("FAIL rstfull_zn got=%b want=1111", b_zn); end
        checks++;
        if (b_in_ready !== 1'b1) begin errors++; $display("FAIL rstfull_in_ready got=%b want=1", b_in_ready); end
        for (int c = 0; c < 3; c++) b_cycle(1'b0, '0, MODE_OAI, 1'b1);
    endtask

    // Random valid/ready backpressure over 10k transactions on B.
    task automatic test_random();
        int acc0;
        int cycles;
        acc0   = b_acc;
        cycles = 0;
        while (b_acc - acc0 < 10000 && cycles < 40000) begin
            b_cycle($urandom_range(0, 3) != 0, 24'($urandom), 1'($urandom),
                    $urandom_range(0, 3) != 0);
            cycles++;
        end
        checks++;
        if (b_acc - acc0 < 10000) begin errors++; $display("FAIL random_budget accepted=%0d want=10000", b_acc - acc0); end
        for (int c = 0; c < 6; c++) b_cycle(1'b0, '0, MODE_OAI, 1'b1);
        checks++;
        if (b_q.size() != 0) begin errors++; $display("FAIL random_drain outstanding=%0d want=0", b_q.size()); end
    endtask

    initial begin
        test_reset();
        test_oai222_all();
        test_lanes();
        test_stall();
        test_back_to_back();
        test_reset_full();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
